// File: rtl/ryuki_datatypes.sv
// Shared pipeline datatypes for the ryuki core trace path.
package ryuki_datatypes;

    // Record produced by the IF-stage tracker when a fetch completes.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [1:0]  priv;
        logic        fault;
    } trace_output;

    localparam int TRACE_BUF_DEPTH_DEFAULT = 8;
    localparam int TRACE_SEQ_WIDTH_DEFAULT = 16;

    // Trace record tagged with its capture sequence number (default width).
    typedef struct packed {
        trace_output                        rec;
        logic [TRACE_SEQ_WIDTH_DEFAULT-1:0] seq;
    } trace_tagged;

endpackage

// File: rtl/trace_fifo.sv
// Generic first-word-fall-through synchronous FIFO with synchronous flush.
// The head element is visible on dout whenever empty is low.
// A pop on an empty FIFO and a push on a full FIFO without a pop are ignored,
// so push and pop while full is legal and leaves count unchanged.
module trace_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  T              din,
    output T              dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    T              mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_ok;
    logic          push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Next pointer/occupancy; flush wins over any push or pop that cycle.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/if_trace_buffer.sv
// Buffers completed IF-stage tracker records, stamping each with a sequence
// number and counting records lost because the buffer was full.
//
// Output handshake: out_valid is high whenever a head record is held and does
// not depend on out_ready; a transfer happens on a rising clk edge where both
// out_valid and out_ready are high. While out_valid is high and out_ready is
// low, out_rec and out_seq are held stable.
module if_trace_buffer
    import ryuki_datatypes::*;
#(
    parameter int DEPTH      = TRACE_BUF_DEPTH_DEFAULT,
    parameter int SEQ_WIDTH  = 16,
    parameter int DROP_WIDTH = 16,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rec_ready_i,
    input  trace_output           rec_i,
    input  logic                  flush_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output trace_output           out_rec,
    output logic [SEQ_WIDTH-1:0]  out_seq,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty,
    output logic [DROP_WIDTH-1:0] drop_count,
    output logic                  overflow
);

    // Same shape as trace_tagged, but with the instance's sequence width.
    typedef struct packed {
        trace_output          rec;
        logic [SEQ_WIDTH-1:0] seq;
    } tagged_t;

    logic                  rec_ready_q, rec_ready_d;
    logic [SEQ_WIDTH-1:0]  seq_ctr_q, seq_ctr_d;
    logic [DROP_WIDTH-1:0] drop_count_q, drop_count_d;
    logic                  overflow_q, overflow_d;

    logic    cap;
    logic    pop;
    logic    push;
    logic    drop;
    tagged_t fifo_din;
    tagged_t fifo_dout;

    // The tracker holds rec_ready_i high until its next fetch, so only the
    // rising edge marks a new record.
    assign cap  = rec_ready_i & ~rec_ready_q;
    assign pop  = out_valid & out_ready;
    assign push = cap & ~flush_i & (~full | pop);
    assign drop = cap & ~flush_i & full & ~pop;

    assign fifo_din.rec = rec_i;
    assign fifo_din.seq = seq_ctr_q;

    trace_fifo #(
        .T     (tagged_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush_i),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Sequence numbers advance on every completion, stored or not, so gaps
    // in out_seq expose drops and flushed captures.
    always_comb begin
        rec_ready_d  = rec_ready_i;
        seq_ctr_d    = seq_ctr_q;
        drop_count_d = drop_count_q;
        overflow_d   = overflow_q | drop;
        if (cap) seq_ctr_d = seq_ctr_q + 1'b1;
        if (drop && (drop_count_q != '1)) drop_count_d = drop_count_q + 1'b1;
    end

    // Edge detect, sequence and drop accounting registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rec_ready_q  <= 1'b0;
            seq_ctr_q    <= '0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            rec_ready_q  <= rec_ready_d;
            seq_ctr_q    <= seq_ctr_d;
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign out_valid  = ~empty;
    assign out_rec    = fifo_dout.rec;
    assign out_seq    = fifo_dout.seq;
    assign drop_count = drop_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_if_trace_buffer.sv
// Bench for if_trace_buffer: directed test-plan scenarios followed by random
// traffic, all compared each cycle against a queue-based reference model.
module tb_if_trace_buffer;
    import ryuki_datatypes::*;

    localparam int DEPTH  = 8;
    localparam int SEQ_W  = 4;
    localparam int DROP_W = 3;
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int RW     = $bits(trace_output);
    localparam int TW     = RW + SEQ_W;
    localparam int DMAX   = (1 << DROP_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              rec_ready_i = 1'b0;
    trace_output       rec_i       = '0;
    logic              flush_i     = 1'b0;
    logic              out_ready   = 1'b0;
    logic              out_valid;
    trace_output       out_rec;
    logic [SEQ_W-1:0]  out_seq;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic [DROP_W-1:0] drop_count;
    logic              overflow;

    if_trace_buffer #(
        .DEPTH      (DEPTH),
        .SEQ_WIDTH  (SEQ_W),
        .DROP_WIDTH (DROP_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rec_ready_i (rec_ready_i),
        .rec_i       (rec_i),
        .flush_i     (flush_i),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rec     (out_rec),
        .out_seq     (out_seq),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .drop_count  (drop_count),
        .overflow    (overflow)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [TW-1:0]    exp_q[$];
    logic [SEQ_W-1:0] m_seq  = '0;
    int               m_drop = 0;
    bit               m_ovf  = 1'b0;
    bit               m_prev = 1'b0;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [TW-1:0] head;
        chk("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
        chk("count", 128'(count), 128'(exp_q.size()));
        chk("full", 128'(full), 128'(exp_q.size() == DEPTH));
        chk("empty", 128'(empty), 128'(exp_q.size() == 0));
        chk("drop_count", 128'(drop_count), 128'(m_drop));
        chk("overflow", 128'(overflow), 128'(m_ovf));
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            chk("out_rec", 128'(out_rec), 128'(head[TW-1:SEQ_W]));
            chk("out_seq", 128'(out_seq), 128'(head[SEQ_W-1:0]));
        end
    endtask

    // Applies the buffer's rules for one clock edge using the current inputs.
    task automatic model_edge();
        bit cap;
        bit pop;
        bit was_full;
        cap      = rec_ready_i && !m_prev;
        pop      = (exp_q.size() != 0) && out_ready;
        was_full = (exp_q.size() == DEPTH);
        m_prev   = rec_ready_i;
        if (flush_i) begin
            exp_q.delete();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (cap) begin
                if (!was_full || pop) begin
                    exp_q.push_back({rec_i, m_seq});
                end else begin
                    if (m_drop < DMAX) m_drop++;
                    m_ovf = 1'b1;
                end
            end
        end
        if (cap) m_seq = m_seq + 1'b1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_seq  = '0;
        m_drop = 0;
        m_ovf  = 1'b0;
        m_prev = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    // Called #1 after a rising edge: check, advance model, cross next edge.
    task automatic cyc();
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted between edges and checked immediately.
    task automatic do_reset();
        #2;
        rst         = 1'b1;
        rec_ready_i = 1'b0;
        flush_i     = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic rand_rec(input logic [31:0] addr);
        rec_i.addr  = addr;
        rec_i.instr = $urandom;
        rec_i.priv  = 2'($urandom_range(0, 3));
        rec_i.fault = 1'($urandom_range(0, 1));
    endtask

    // One tracker completion: level held high for 'hold' cycles, then low.
    task automatic complete(input logic [31:0] addr, input int hold);
        rand_rec(addr);
        rec_ready_i = 1'b1;
        repeat (hold) cyc();
        rec_ready_i = 1'b0;
        cyc();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Single record held for five cycles, sink always ready.
        out_ready = 1'b1;
        complete(32'h100, 5);
        repeat (2) cyc();

        // Fill and overflow: ten completions into a stalled sink, then drain.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) complete(32'h200 + 32'(i * 4), 1);
        out_ready = 1'b1;
        repeat (10) cyc();

        // Full FIFO with a pop in the same cycle as a capture.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) complete(32'h300 + 32'(i * 4), 1);
        rand_rec(32'h3f0);
        rec_ready_i = 1'b1;
        out_ready   = 1'b1;
        cyc();
        rec_ready_i = 1'b0;
        out_ready   = 1'b0;
        cyc();
        out_ready = 1'b1;
        repeat (10) cyc();

        // Sequence wrap: seventeen completions with a free-flowing sink.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) complete(32'h400 + 32'(i * 4), 1);
        repeat (2) cyc();

        // Flush coincident with a capture.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) complete(32'h500 + 32'(i * 4), 1);
        rand_rec(32'h5f0);
        rec_ready_i = 1'b1;
        flush_i     = 1'b1;
        cyc();
        flush_i     = 1'b0;
        rec_ready_i = 1'b0;
        cyc();
        complete(32'h600, 1);
        out_ready = 1'b1;
        repeat (2) cyc();

        // Drop counter saturation.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + DMAX + 3; i++) complete(32'h700 + 32'(i * 4), 1);

        // Async reset with five records buffered and three drops recorded.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) complete(32'h800 + 32'(i * 4), 1);
        out_ready = 1'b1;
        repeat (3) cyc();
        out_ready = 1'b0;
        cyc();
        do_reset();
        out_ready = 1'b1;
        complete(32'h900, 2);
        cyc();

        // Random traffic: levels, records, sink stalls and rare flushes.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                if (!rec_ready_i) rand_rec($urandom);
                rec_ready_i = ~rec_ready_i;
            end
            out_ready = ($urandom_range(0, 3) != 0) ^ ((i / 64) % 3 == 2);
            flush_i   = ($urandom_range(0, 39) == 0);
            cyc();
        end
        flush_i     = 1'b0;
        rec_ready_i = 1'b0;
        out_ready   = 1'b1;
        repeat (DEPTH + 2) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_trace_buffer.md
Name: if_trace_buffer

Overview:
- Sits directly downstream of the IF-stage tracker and consumes its completed fetch records.
- Captures one trace_output record per tracker completion into a FIFO and stamps each with a sequence number.
- Presents records first-word-fall-through on a valid/ready port toward the trace sink / ID tracker.
- Counts records lost to overflow.

Parameters:
- DEPTH, 8: FIFO entries (power of two, >=2).
- SEQ_WIDTH, 16: sequence-number width.
- DROP_WIDTH, 16: drop-counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rec_ready_i  in  1  tracker completion level; rises when a record is complete, holds high until the tracker starts its next fetch
- rec_i  in  trace_output  tracker record; stable while rec_ready_i is high
- flush_i  in  1  synchronous clear of buffered records
- out_valid  out  1  head record available
- out_ready  in  1  sink accepts head
- out_rec  out  trace_output  head record
- out_seq  out  SEQ_WIDTH  sequence number of head record
- count  out  $clog2(DEPTH+1)  occupancy
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- drop_count  out  DROP_WIDTH  records lost to overflow, saturating
- overflow  out  1  sticky: at least one drop since reset

Behaviour:
- Reset (async, rst=1):
  - rd_ptr, wr_ptr, count, seq_ctr, drop_count, overflow, and rec_ready_q go to 0.
  - Outputs: out_valid=0, empty=1, full=0.
  - out_rec/out_seq are don't-care while out_valid=0.
  - Reset mid-transfer discards all contents; no partial state survives.
- Capture event:
  - cap = rec_ready_i & ~rec_ready_q, where rec_ready_q is rec_ready_i registered.
  - One event per tracker completion. A level held high for N cycles yields exactly one capture.
  - If rec_ready_i=1 on the first clock after reset, that is a capture.
- Sequence counter:
  - seq_ctr increments by 1 on every cap, whether the record is stored, dropped or flushed.
  - Wraps modulo 2^SEQ_WIDTH.
  - The stored record is tagged with the pre-increment value, so a gap in out_seq reveals drops.
- pop = out_valid & out_ready.
- push = cap & ~flush_i & (~full | pop).
  - Simultaneous push and pop while full is legal: count stays DEPTH and both pointers advance.
- Drop:
  - Condition: cap & ~flush_i & full & ~pop.
  - drop_count increments, saturating at 2^DROP_WIDTH-1.
  - overflow sets and stays set until reset (flush_i does not clear it).
- Latency: a record captured at edge k appears on out_rec/out_valid after edge k. An empty FIFO therefore shows out_valid=1 the cycle after cap.
- FWFT: out_rec = mem[rd_ptr], out_seq = seq_mem[rd_ptr], out_valid = ~empty. The head is held stable while out_valid & ~out_ready.
- Pointers are log2(DEPTH) bits and wrap naturally. count is updated +1 on push only, -1 on pop only, unchanged on both or neither.
- flush_i (synchronous, highest priority below rst):
  - rd_ptr = wr_ptr = count = 0; an in-flight pop or push that cycle is ignored.
  - A cap in the flush cycle is discarded, not counted as a drop, but seq_ctr still increments.
  - drop_count and overflow are retained.
- Single clock domain; no combinational path from rec_ready_i to out_valid.

Decomposition:
- The trace_output typedef stays in ryuki_datatypes; this block imports it.
- Add to ryuki_datatypes: localparam TRACE_BUF_DEPTH_DEFAULT = 8, plus a trace_tagged struct {trace_output rec; logic [SEQ_WIDTH-1:0] seq}.
- One natural sub-module: trace_fifo, a generic FWFT synchronous FIFO (push, pop, flush, count, full, empty), parameterised on element type and depth.
- Edge detect, sequence counter and drop accounting remain in if_trace_buffer.

Test Plan:
- Single record: rec_ready_i rises with rec_i.addr=0x100, held 5 cycles; out_ready=1 -> exactly one out_valid pulse of 1 cycle, out_rec.addr=0x100, out_seq=0, count returns to 0.
- Fill and overflow (DEPTH=8, out_ready=0): 10 completions -> count=8, full=1, drop_count=2, overflow=1. Draining yields seq 0..7 in order.
- Full with simultaneous pop/push: FIFO full, out_ready=1 on the same cycle as a cap -> no drop, count stays 8, new record's seq lands at the tail.
- Sequence wrap (SEQ_WIDTH=4): 17 completions with out_ready=1 -> out_seq runs 0..15 then 0.
- Flush with concurrent cap: 3 records buffered, flush_i and cap asserted in the same cycle -> empty=1, drop_count unchanged, next captured record has out_seq=4.
- Async reset mid-operation: 5 records buffered with drop_count=3, assert rst between clock edges -> out_valid=0, count=0, drop_count=0, overflow=0 immediately. The first post-reset record has seq=0.
